downstream_stream_adp: RTL and testbench

- Parametrised next-generation AXI-stream-to-GEP write adaptor.
- Accepts one event per packet (TID = BCID) from the AXI-stream fabric and writes data words to GEP event memory starting at address 1.
- After the last word, writes a header word at address 0 carrying word count, BCID and an overflow flag, and pulses wr_EvTID_DONE.
- Adds downstream backpressure, TKEEP byte masking, overflow protection and discard of TID==0 packets.

---
 rtl/downstream_stream_adp_if.sv | 30 +++
 rtl/downstream_stream_adp.sv | 200 ++++++++++++++++++++
 tb/tb_downstream_stream_adp.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/downstream_stream_adp_if.sv
// rtl/downstream_stream_adp_if.sv - stream input and GEP write bus of the downstream adaptor
interface downstream_stream_adp_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 10,
  parameter int ID_W   = 11
);
  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_W-1:0]     TDATA;
  logic [DATA_W/8-1:0]   TKEEP;
  logic                  TLAST;
  logic [ID_W-1:0]       TID;
  logic                  wr_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_EvTID_DONE;

  // Stream source / memory sink side
  modport master (
    output TVALID, TDATA, TKEEP, TLAST, TID, wr_ready,
    input  TREADY, wr_en, wr_addr, wr_data, wr_EvTID_DONE
  );

  // Adaptor side
  modport slave (
    input  TVALID, TDATA, TKEEP, TLAST, TID, wr_ready,
    output TREADY, wr_en, wr_addr, wr_data, wr_EvTID_DONE
  );
endinterface

// File: rtl/downstream_stream_adp.sv
// rtl/downstream_stream_adp.sv - AXI-stream to GEP event memory write adaptor (option: DOWNSTREAM_STREAM_ADP_STATS_EN)
module downstream_stream_adp #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 10,
  parameter int ID_W      = 11,
  parameter int MAX_WORDS = 2**ADDR_W-1
) (
  input  logic                    clk,
  input  logic                    ARESETn,
  downstream_stream_adp_if.slave  s,
  output logic                    ovf_err
`ifdef DOWNSTREAM_STREAM_ADP_STATS_EN
  ,
  output logic [31:0]             evt_cnt,
  output logic [31:0]             drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2,
    HDR  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] MAX_W = ADDR_W'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]   bcid_q, bcid_d;
  logic              pkt_ovf_q, pkt_ovf_d;
  logic              nohdr_q, nohdr_d;
  logic              ovf_err_q, ovf_err_d;

  logic [DATA_W-1:0] masked_data;
  logic [DATA_W-1:0] hdr_word;
  logic [ADDR_W-1:0] cnt_inc;
  logic              hdr_wr;
  logic              drop_last;

  logic              tready_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              done_c;

  // Zero the bytes the source marked as not kept
  always_comb begin
    masked_data = '0;
    for (int i = 0; i < DATA_W/8; i++) begin
      masked_data[i*8 +: 8] = s.TKEEP[i] ? s.TDATA[i*8 +: 8] : 8'h00;
    end
  end

  // Header word: count, BCID and overflow flag packed from bit 0 upwards
  always_comb begin
    hdr_word                 = '0;
    hdr_word[ADDR_W-1:0]     = cnt_q;
    hdr_word[ADDR_W +: ID_W] = bcid_q;
    hdr_word[ADDR_W+ID_W]    = pkt_ovf_q;
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    bcid_d    = bcid_q;
    pkt_ovf_d = pkt_ovf_q;
    nohdr_d   = nohdr_q;
    ovf_err_d = ovf_err_q;
    tready_c  = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_data_c = '0;
    done_c    = 1'b0;
    hdr_wr    = 1'b0;
    drop_last = 1'b0;
    cnt_inc   = cnt_q + ONE;

    case (state_q)
      IDLE: begin
        // Only the TID is inspected here; the first beat is consumed in DATA/DROP
        if (s.TVALID) begin
          if (s.TID != '0) begin
            bcid_d    = s.TID;
            addr_d    = ONE;
            cnt_d     = '0;
            pkt_ovf_d = 1'b0;
            state_d   = DATA;
          end else begin
            nohdr_d = 1'b1;
            state_d = DROP;
          end
        end
      end

      DATA: begin
        tready_c  = s.wr_ready;
        wr_en_c   = s.TVALID & s.wr_ready;
        wr_addr_c = addr_q;
        wr_data_c = masked_data;
        if (s.TVALID && s.wr_ready) begin
          addr_d = addr_q + ONE;
          cnt_d  = cnt_inc;
          if (s.TLAST) begin
            state_d = HDR;
          end else if (cnt_inc == MAX_W) begin
            // Memory window full but packet continues: flush the rest
            pkt_ovf_d = 1'b1;
            ovf_err_d = 1'b1;
            nohdr_d   = 1'b0;
            state_d   = DROP;
          end
        end
      end

      DROP: begin
        tready_c = 1'b1;
        if (s.TVALID && s.TLAST) begin
          drop_last = 1'b1;
          state_d   = nohdr_q ? IDLE : HDR;
        end
      end

      HDR: begin
        wr_en_c   = s.wr_ready;
        done_c    = s.wr_ready;
        wr_data_c = hdr_word;
        if (s.wr_ready) begin
          hdr_wr  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and packet context registers
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= ONE;
      cnt_q     <= '0;
      bcid_q    <= '0;
      pkt_ovf_q <= 1'b0;
      nohdr_q   <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      bcid_q    <= bcid_d;
      pkt_ovf_q <= pkt_ovf_d;
      nohdr_q   <= nohdr_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  assign s.TREADY        = tready_c;
  assign s.wr_en         = wr_en_c;
  assign s.wr_addr       = wr_addr_c;
  assign s.wr_data       = wr_data_c;
  assign s.wr_EvTID_DONE = done_c;
  assign ovf_err         = ovf_err_q;

`ifdef DOWNSTREAM_STREAM_ADP_STATS_EN
  logic [31:0] evt_cnt_q, evt_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Free-running event and discard counters, wrapping naturally
  always_comb begin
    evt_cnt_d  = evt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (hdr_wr)    evt_cnt_d  = evt_cnt_q + 32'd1;
    if (drop_last) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      evt_cnt_q  <= evt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign evt_cnt  = evt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hdr_wr ^ drop_last;
`endif

endmodule

// File: tb/tb_downstream_stream_adp.sv
// tb/tb_downstream_stream_adp.sv - directed bench for downstream_stream_adp
module tb_downstream_stream_adp;

  logic clk;
  logic ARESETn;
  logic ovf_err;
`ifdef DOWNSTREAM_STREAM_ADP_STATS_EN
  logic [31:0] evt_cnt;
  logic [31:0] drop_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0]   log_addr[$];
  logic [127:0] log_data[$];
  logic         log_done[$];

  downstream_stream_adp_if #(.DATA_W(128), .ADDR_W(10), .ID_W(11)) s ();

  downstream_stream_adp #(
    .DATA_W(128), .ADDR_W(10), .ID_W(11), .MAX_WORDS(4)
  ) dut (
    .clk     (clk),
    .ARESETn (ARESETn),
    .s       (s.slave),
    .ovf_err (ovf_err)
`ifdef DOWNSTREAM_STREAM_ADP_STATS_EN
    ,
    .evt_cnt (evt_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dat(input int k);
    logic [31:0] w;
    w = 32'hA5000000 + 32'(k);
    return {4{w}};
  endfunction

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (s.wr_en) begin
      log_addr.push_back(s.wr_addr);
      log_data.push_back(s.wr_data);
      log_done.push_back(s.wr_EvTID_DONE);
      if (!s.wr_EvTID_DONE) check("data_addr_nonzero", 128'(s.wr_addr != 10'd0), 128'd1);
    end
    if (s.wr_EvTID_DONE) check("done_with_hdr_write", {s.wr_en, s.wr_addr == 10'd0}, 128'b11);
  end

  task automatic expect_write(input string tag, input logic [9:0] a, input logic [127:0] d, input logic dn);
    if (log_addr.size() == 0) begin
      check({tag, "_present"}, 128'(log_addr.size()), 128'd1);
    end else begin
      check({tag, "_addr"}, 128'(log_addr.pop_front()), 128'(a));
      check({tag, "_data"}, log_data.pop_front(), d);
      check({tag, "_done"}, 128'(log_done.pop_front()), 128'(dn));
    end
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_no_extra_writes"}, 128'(log_addr.size()), 128'd0);
    log_addr.delete();
    log_data.delete();
    log_done.delete();
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                           input logic [10:0] id, input int stall);
    int n;
    s.TVALID = 1'b1;
    s.TDATA  = d;
    s.TKEEP  = k;
    s.TLAST  = l;
    s.TID    = id;
    if (stall > 0) begin
      s.wr_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        check("stall_tready", 128'(s.TREADY), 128'd0);
        check("stall_wr_en", 128'(s.wr_en), 128'd0);
        @(posedge clk);
        #1;
      end
      s.wr_ready = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!s.TREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s.TREADY) check("beat_timeout", 128'(s.TREADY), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [10:0] id, input int n, input int base,
                          input int stall_beat, input int stall_n, input int hdr_stall);
    for (int k = 0; k < n; k++) begin
      send_beat(dat(base + k), 16'hFFFF, k == n - 1, id, (k == stall_beat) ? stall_n : 0);
    end
    s.TVALID = 1'b0;
    s.TLAST  = 1'b0;
    if (hdr_stall > 0) begin
      s.wr_ready = 1'b0;
      repeat (hdr_stall) begin
        @(negedge clk);
        check("hdr_hold_wr_en", 128'(s.wr_en), 128'd0);
        check("hdr_hold_done", 128'(s.wr_EvTID_DONE), 128'd0);
        check("hdr_tready", 128'(s.TREADY), 128'd0);
        @(posedge clk);
        #1;
      end
      s.wr_ready = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_pkt(input string tag, input int nw, input int base, input logic [127:0] hdr);
    for (int k = 0; k < nw; k++) begin
      expect_write($sformatf("%s_beat%0d", tag, k), 10'(k + 1), dat(base + k), 1'b0);
    end
    expect_write({tag, "_hdr"}, 10'd0, hdr, 1'b1);
    expect_empty(tag);
  endtask

  initial begin
    ARESETn    = 1'b0;
    s.TVALID   = 1'b0;
    s.TDATA    = '0;
    s.TKEEP    = '0;
    s.TLAST    = 1'b0;
    s.TID      = '0;
    s.wr_ready = 1'b1;
    #2;
    check("rst_tready", 128'(s.TREADY), 128'd0);
    check("rst_wr_en", 128'(s.wr_en), 128'd0);
    check("rst_done", 128'(s.wr_EvTID_DONE), 128'd0);
    check("rst_ovf_err", 128'(ovf_err), 128'd0);
    #21;
    ARESETn = 1'b1;
    @(posedge clk);
    #1;

    // Basic 3-beat packet
    send_pkt(11'd5, 3, 0, -1, 0, 0);
    check_pkt("basic", 3, 0, 128'h1403);

    // Backpressure mid-packet and in HDR
    send_pkt(11'd5, 3, 10, 1, 2, 3);
    check_pkt("bp", 3, 10, 128'h1403);

    // Byte masking
    send_beat({128{1'b1}}, 16'h00FF, 1'b1, 11'd3, 0);
    s.TVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_write("keep", 10'd1, 128'h0000000000000000FFFFFFFFFFFFFFFF, 1'b0);
    expect_write("keep_hdr", 10'd0, 128'hC01, 1'b1);
    expect_empty("keep");

    // Overflow: 6 beats with MAX_WORDS=4
    send_pkt(11'd7, 6, 20, -1, 0, 0);
    check_pkt("ovf", 4, 20, 128'h201C04);
    check("ovf_err_set", 128'(ovf_err), 128'd1);

    // Exactly MAX_WORDS beats
    send_pkt(11'd7, 4, 30, -1, 0, 0);
    check_pkt("exact", 4, 30, 128'h1C04);
    check("ovf_err_sticky", 128'(ovf_err), 128'd1);

    // TID==0 packet discarded
    send_beat(dat(60), 16'hFFFF, 1'b0, 11'd0, 0);
    @(negedge clk);
    check("drop_tready", 128'(s.TREADY), 128'd1);
    check("drop_wr_en", 128'(s.wr_en), 128'd0);
    send_beat(dat(61), 16'hFFFF, 1'b1, 11'd0, 0);
    s.TVALID = 1'b0;
    s.TLAST  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_empty("tid0");
`ifdef DOWNSTREAM_STREAM_ADP_STATS_EN
    check("stats_evt_cnt", 128'(evt_cnt), 128'd5);
    check("stats_drop_cnt", 128'(drop_cnt), 128'd2);
`endif

    // Reset during beat 2 of 4
    send_beat(dat(40), 16'hFFFF, 1'b0, 11'd11, 0);
    s.TDATA = dat(41);
    #2;
    ARESETn = 1'b0;
    #1;
    check("arst_tready", 128'(s.TREADY), 128'd0);
    check("arst_wr_en", 128'(s.wr_en), 128'd0);
    check("arst_done", 128'(s.wr_EvTID_DONE), 128'd0);
    check("arst_ovf_err", 128'(ovf_err), 128'd0);
    check("arst_wr_addr", 128'(s.wr_addr), 128'd0);
    s.TVALID = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    ARESETn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_write("arst_beat0", 10'd1, dat(40), 1'b0);
    expect_empty("arst_no_hdr");
    send_pkt(11'd9, 2, 50, -1, 0, 0);
    check_pkt("post_rst", 2, 50, 128'h2402);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
